// File: rtl/ftoi_pipe.sv
// Three-stage IEEE-754 single -> int32 converter, round to nearest, ties away from zero.
// Define FTOI_SAT_EN for saturating out-of-range results; otherwise they read 0x80000000.
module ftoi_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_y,
    output logic        out_ovf
);

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_HALF = 2'd1,
        CLS_NORM = 2'd2,
        CLS_BIG  = 2'd3
    } cls_t;

    logic        stall_s;
    logic        v1_r, v2_r, v3_r;

    cls_t        cls_s;
    logic        s1_sign_r;
    logic [7:0]  s1_exp_r;
    logic [23:0] s1_man_r;
    cls_t        s1_cls_r;
    logic        s1_nan_r;
    logic        s1_min_r;

    logic [4:0]  rsh_s;
    logic [2:0]  lsh_s;
    logic [24:0] shr_s;
    logic [31:0] shl_s;
    logic [31:0] mag_s;
    logic        g_s;
    logic        s2_sign_r;
    cls_t        s2_cls_r;
    logic        s2_nan_r;
    logic        s2_min_r;
    logic [31:0] s2_mag_r;
    logic        s2_g_r;

    logic [31:0] r_s;
    logic [31:0] special_s;
    logic [31:0] y_s;
    logic        ovf_s;

    assign stall_s   = v3_r & ~out_ready;
    assign in_ready  = ~stall_s;
    assign out_valid = v3_r;

    // Classify the incoming exponent.
    always_comb begin
        cls_s = CLS_ZERO;
        if (in_x[30:23] < 8'd126) begin
            cls_s = CLS_ZERO;
        end else if (in_x[30:23] == 8'd126) begin
            cls_s = CLS_HALF;
        end else if (in_x[30:23] <= 8'd157) begin
            cls_s = CLS_NORM;
        end else begin
            cls_s = CLS_BIG;
        end
    end

    // Stage 1 registers: unpacked operand and its class.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r      <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_exp_r  <= 8'd0;
            s1_man_r  <= 24'd0;
            s1_cls_r  <= CLS_ZERO;
            s1_nan_r  <= 1'b0;
            s1_min_r  <= 1'b0;
        end else if (!stall_s) begin
            v1_r      <= in_valid;
            s1_sign_r <= in_x[31];
            s1_exp_r  <= in_x[30:23];
            s1_man_r  <= {1'b1, in_x[22:0]};
            s1_cls_r  <= cls_s;
            s1_nan_r  <= (in_x[30:23] == 8'hFF) && (in_x[22:0] != 23'd0);
            s1_min_r  <= (in_x == 32'hCF00_0000);
        end else begin
            v1_r      <= v1_r;
        end
    end

    // The extra low bit of the right shift catches the guard bit for free.
    always_comb begin
        rsh_s = 5'(8'd150 - s1_exp_r);
        lsh_s = 3'(s1_exp_r - 8'd150);
        shr_s = {s1_man_r, 1'b0} >> rsh_s;
        shl_s = {8'd0, s1_man_r} << lsh_s;
        mag_s = 32'd0;
        g_s   = 1'b0;
        case (s1_cls_r)
            CLS_HALF: begin
                mag_s = 32'd0;
                g_s   = 1'b1;
            end
            CLS_NORM: begin
                if (s1_exp_r <= 8'd150) begin
                    mag_s = {8'd0, shr_s[24:1]};
                    g_s   = shr_s[0];
                end else begin
                    mag_s = shl_s;
                    g_s   = 1'b0;
                end
            end
            default: begin
                mag_s = 32'd0;
                g_s   = 1'b0;
            end
        endcase
    end

    // Stage 2 registers: shifted magnitude and guard bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r      <= 1'b0;
            s2_sign_r <= 1'b0;
            s2_cls_r  <= CLS_ZERO;
            s2_nan_r  <= 1'b0;
            s2_min_r  <= 1'b0;
            s2_mag_r  <= 32'd0;
            s2_g_r    <= 1'b0;
        end else if (!stall_s) begin
            v2_r      <= v1_r;
            s2_sign_r <= s1_sign_r;
            s2_cls_r  <= s1_cls_r;
            s2_nan_r  <= s1_nan_r;
            s2_min_r  <= s1_min_r;
            s2_mag_r  <= mag_s;
            s2_g_r    <= g_s;
        end else begin
            v2_r      <= v2_r;
        end
    end

    // Value reported for NaN, infinities and out-of-range magnitudes.
    always_comb begin
        special_s = 32'h8000_0000;
`ifdef FTOI_SAT_EN
        if (s2_nan_r) begin
            special_s = 32'h0000_0000;
        end else if (s2_sign_r) begin
            special_s = 32'h8000_0000;
        end else begin
            special_s = 32'h7FFF_FFFF;
        end
`else
        special_s = 32'h8000_0000;
`endif
    end

    // Round, apply sign, and pick the special-case result.
    always_comb begin
        r_s   = s2_mag_r + {31'd0, s2_g_r};
        y_s   = 32'd0;
        ovf_s = 1'b0;
        case (s2_cls_r)
            CLS_ZERO: begin
                y_s   = 32'd0;
                ovf_s = 1'b0;
            end
            CLS_HALF, CLS_NORM: begin
                y_s   = s2_sign_r ? (32'd0 - r_s) : r_s;
                ovf_s = 1'b0;
            end
            CLS_BIG: begin
                if (s2_min_r) begin
                    y_s   = 32'h8000_0000;
                    ovf_s = 1'b0;
                end else begin
                    y_s   = special_s;
                    ovf_s = 1'b1;
                end
            end
            default: begin
                y_s   = 32'd0;
                ovf_s = 1'b0;
            end
        endcase
    end

    // Stage 3 registers drive the outputs directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_r    <= 1'b0;
            out_y   <= 32'd0;
            out_ovf <= 1'b0;
        end else if (!stall_s) begin
            v3_r    <= v2_r;
            out_y   <= y_s;
            out_ovf <= ovf_s;
        end else begin
            v3_r    <= v3_r;
        end
    end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed-vector and stream bench for ftoi_pipe; expected values come from a
// hand-written table and an independent 64-bit fixed-point reference model.
module tb_ftoi_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_y;
    logic        out_ovf;

    int total;
    int bad;

    typedef struct {
        logic [31:0] x;
        logic [31:0] y;
        logic        ovf;
    } vec_t;

`ifdef FTOI_SAT_EN
    localparam logic [31:0] POS_OVF_Y = 32'h7FFF_FFFF;
    localparam logic [31:0] NAN_Y     = 32'h0000_0000;
`else
    localparam logic [31:0] POS_OVF_Y = 32'h8000_0000;
    localparam logic [31:0] NAN_Y     = 32'h8000_0000;
`endif

    vec_t        vecs[20];
    logic [31:0] stim[100];

    ftoi_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [31:0] x, output logic [31:0] y, output logic o);
        logic [7:0]  e;
        logic [63:0] fx;
        logic [31:0] r;
        e = x[30:23];
        o = 1'b0;
        y = 32'd0;
        r = 32'd0;
        if (e >= 8'd158) begin
            if (x == 32'hCF00_0000) begin
                y = 32'h8000_0000;
            end else begin
                o = 1'b1;
                if (e == 8'hFF && x[22:0] != 23'd0) y = NAN_Y;
                else if (x[31]) y = 32'h8000_0000;
                else y = POS_OVF_Y;
            end
        end else begin
            if (e >= 8'd118) begin
                fx = {40'd0, 1'b1, x[22:0]} << (e - 8'd118);
                r  = fx[63:32] + {31'd0, fx[31]};
            end
            y = x[31] ? (32'd0 - r) : r;
        end
    endfunction

    task automatic run_one(input logic [31:0] x, input logic [31:0] ey, input logic eo, input string nm);
        int lat;
        @(negedge clk);
        in_x      = x;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        chk({nm, "_latency"}, lat, 32'd3);
        chk({nm, "_y"}, out_y, ey);
        chk({nm, "_ovf"}, {31'd0, out_ovf}, {31'd0, eo});
    endtask

    task automatic run_stream(input int n, input int stall_len, input string nm);
        int          sent;
        int          got;
        int          stall_left;
        int          first_cyc;
        bit          seen;
        logic [31:0] ey;
        logic        eo;
        sent       = 0;
        got        = 0;
        stall_left = 0;
        first_cyc  = 0;
        seen       = 1'b0;
        for (int cyc = 0; cyc < n + 40 && got < n; cyc++) begin
            @(negedge clk);
            if (out_valid && !seen) begin
                seen       = 1'b1;
                stall_left = stall_len;
            end
            out_ready = (stall_left == 0);
            in_valid  = (sent < n);
            in_x      = (sent < n) ? stim[sent] : 32'd0;
            #1;
            if (stall_left > 0) begin
                model(stim[got], ey, eo);
                chk({nm, "_stall_in_ready"}, {31'd0, in_ready}, 32'd0);
                chk({nm, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
                chk({nm, "_stall_hold_y"}, out_y, ey);
                stall_left--;
            end
            if (out_valid && out_ready) begin
                model(stim[got], ey, eo);
                chk($sformatf("%s_y%0d", nm, got), out_y, ey);
                chk($sformatf("%s_ovf%0d", nm, got), {31'd0, out_ovf}, {31'd0, eo});
                if (got == 0) first_cyc = cyc;
                else if (stall_len == 0) chk($sformatf("%s_gap%0d", nm, got), cyc, first_cyc + got);
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        chk({nm, "_count"}, got, n);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk({nm, "_drained"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] e;
        total = 0;
        bad   = 0;
        clk       = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_x      = 32'd0;
        out_ready = 1'b1;

        vecs[0]  = '{32'h3FC0_0000, 32'h0000_0002, 1'b0};
        vecs[1]  = '{32'h3F00_0000, 32'h0000_0001, 1'b0};
        vecs[2]  = '{32'hBF00_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[3]  = '{32'h3EFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{32'h4020_0000, 32'h0000_0003, 1'b0};
        vecs[5]  = '{32'h8000_0000, 32'h0000_0000, 1'b0};
        vecs[6]  = '{32'h4B00_0001, 32'h0080_0001, 1'b0};
        vecs[7]  = '{32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0};
        vecs[8]  = '{32'hCF00_0000, 32'h8000_0000, 1'b0};
        vecs[9]  = '{32'h4F00_0000, POS_OVF_Y,     1'b1};
        vecs[10] = '{32'h7F80_0000, POS_OVF_Y,     1'b1};
        vecs[11] = '{32'hFF80_0000, 32'h8000_0000, 1'b1};
        vecs[12] = '{32'h7FC0_0000, NAN_Y,         1'b1};
        vecs[13] = '{32'hC020_0000, 32'hFFFF_FFFD, 1'b0};
        vecs[14] = '{32'h3F80_0000, 32'h0000_0001, 1'b0};
        vecs[15] = '{32'hCF00_0001, 32'h8000_0000, 1'b1};
        vecs[16] = '{32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[17] = '{32'h3F7F_FFFF, 32'h0000_0001, 1'b0};
        vecs[18] = '{32'hC2F6_0000, 32'hFFFF_FF85, 1'b0};
        vecs[19] = '{32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0};

        #3;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_y", out_y, 32'd0);
        chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        #14;
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            run_one(vecs[i].x, vecs[i].y, vecs[i].ovf, $sformatf("vec%0d", i));
        end

        stim[0] = 32'h3FC0_0000;
        stim[1] = 32'h4020_0000;
        stim[2] = 32'hBF00_0000;
        stim[3] = 32'h4F00_0000;
        stim[4] = 32'h4B00_0001;
        run_stream(5, 4, "bp");

        for (int i = 0; i < 100; i++) begin
            e = 8'($urandom_range(110, 160));
            stim[i] = {1'($urandom_range(0, 1)), e, 23'($urandom)};
        end
        run_stream(100, 0, "thru");

        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_x      = 32'h3F80_0000;
        @(negedge clk);
        in_x      = 32'h4000_0000;
        @(negedge clk);
        in_x      = 32'h4040_0000;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_y", out_y, 32'd0);
        chk("async_rst_ovf", {31'd0, out_ovf}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("no_stale%0d", k), {31'd0, out_valid}, 32'd0);
        end
        run_one(32'h4120_0000, 32'h0000_000A, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ftoi_pipe.md
# ftoi_pipe

Pipelined IEEE-754 single-precision to signed 32-bit integer converter, the inverse of the FPU's int-to-float path, used by the CPU's `ftoi` instruction. Accepts one float per cycle over a valid/ready handshake and returns the rounded integer three cycles later. Rounding is to nearest, ties away from zero. Out-of-range and NaN inputs are flagged.

## Interface
- No parameters.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: `in_x` carries an operand.
- `in_ready` out 1: converter accepts the operand this cycle.
- `in_x` in 32: float operand (sign, exp[30:23], mant[22:0]).
- `out_valid` out 1: `out_y`/`out_ovf` are valid.
- `out_ready` in 1: consumer takes the result this cycle.
- `out_y` out 32: two's-complement result.
- `out_ovf` out 1: input was NaN, ±Inf, or its magnitude exceeded the int32 range.

## Operation
- Pipeline stages, each guarded by a valid bit v1/v2/v3; `out_valid` = v3.
- **S1:** register sign s, exponent e, and m = {1, mant} (24 bits). Classify:
  - zero: e < 126, which also covers denormals and ±0.
  - half: e = 126.
  - normal: 127 ≤ e ≤ 157.
  - big: e ≥ 158.
  - NaN: e = 255 with mant ≠ 0.
- **S2:** shift the magnitude.
  - e ≤ 150: mag = m >> (150−e); guard g = bit (149−e) of m.
  - 151 ≤ e ≤ 157: mag = m << (e−150); g = 0.
  - half class: mag = 0, g = 1.
  - Shift amount is 0..23 right or 1..7 left, computed in 5 bits.
- **S3:** round, negate, and select specials.
  - r = mag + g. No overflow is possible: max r = 0x7FFFFF80.
  - out_y = s ? −r : r. Zero class gives 0, including for −0.
  - big class with in_x = 0xCF000000 (exactly −2^31): out_y = 0x80000000, out_ovf = 0.
  - Other big class, ±Inf, and NaN: out_ovf = 1; out_y per Configuration.
- Handshake:
  - Global stall: stall = v3 & ~out_ready. `in_ready` = ~stall.
  - When not stalled, all stages advance: v1 ← in_valid, v2 ← v1, v3 ← v2, and data moves with them.
  - When stalled, every stage register holds. Bubbles are not collapsed.
  - A transfer occurs on a cycle where valid and ready are both high. Results leave in input order.
- Data registers may update on cycles with an invalid entry. Only valid-qualified outputs are specified.

## Timing
- Latency: an operand accepted at edge N appears with `out_valid`=1 after edge N+3, given no stall.
- Throughput: 1 result/cycle while `out_ready`=1.
- `in_ready` is combinational from `out_ready` and v3. No other in→out combinational path exists.
- While stalled: `out_y`, `out_ovf` and `out_valid` are held stable. An `in_x` offered while `in_ready`=0 is not taken.
- Simultaneous input acceptance and output drain in one cycle is legal, with no loss.
- Reset: v1, v2 and v3 clear immediately. `out_valid`=0, `out_y`=0, `out_ovf`=0, `in_ready`=1.
  - Reset mid-operation discards all in-flight operands; nothing is emitted for them after release.
- First acceptance is possible on the first rising edge after `rst` deasserts.

## Configuration
- `FTOI_SAT_EN` defined: saturating results.
  - Positive overflow or +Inf → 0x7FFFFFFF.
  - Negative overflow or −Inf → 0x80000000.
  - NaN → 0x00000000.
- Undefined: every out-of-range, ±Inf or NaN input → 0x80000000.
- `out_ovf` behaviour is identical in both builds.

## Test plan
- Rounding, with `out_ready`=1 and no backpressure:
  - 0x3FC00000 (1.5) → 2
  - 0x3F000000 (0.5) → 1
  - 0xBF000000 (−0.5) → 0xFFFFFFFF
  - 0x3EFFFFFF → 0
  - 0x40200000 (2.5) → 3
  - 0x80000000 → 0
  - All with out_ovf=0 and each result exactly 3 cycles after acceptance.
- Range edges:
  - 0x4B000001 → 8388609.
  - 0x4EFFFFFF → 0x7FFFFF80, out_ovf=0.
  - 0xCF000000 → 0x80000000, out_ovf=0.
  - 0x4F000000 → out_ovf=1; out_y = 0x7FFFFFFF with `FTOI_SAT_EN`, else 0x80000000.
- Specials:
  - 0x7F800000 → ovf=1; y = 0x7FFFFFFF (SAT) / 0x80000000.
  - 0xFF800000 → ovf=1; y = 0x80000000 in both builds.
  - 0x7FC00000 → ovf=1; y = 0 (SAT) / 0x80000000.
- Backpressure:
  - Stimulus: 5 back-to-back operands, then `out_ready`=0 for 4 cycles starting when the first result appears.
  - `out_y` is held for those 4 cycles and `in_ready`=0 throughout.
  - All 5 results emerge in order with none lost or duplicated.
- Throughput: 100 random operands with `in_valid`/`out_ready` held high → 100 results on consecutive cycles, all matching the reference model.
- Reset mid-flight:
  - Stimulus: assert `rst` asynchronously (between edges) with 3 operands in flight.
  - `out_valid` falls without waiting for an edge and no stale result appears after release.
  - The next operand, 0x41200000 (10.0), returns 10 three cycles after acceptance.
